instruction_register: RTL and testbench
=======================================

Name: instruction_register

Overview:
- Holds the 16-bit instruction fetched from memory in the multicycle datapath.
- Loads only when the control unit asserts IRWrite; holds otherwise.
- Decodes the held word into fixed 4-bit fields (opcode, two source registers, destination register) for the register file and control unit.
- Sits between instruction memory and control/register-file decode.

Parameters:
- INSTR_W, 16, instruction width; fixed at 16, other values unsupported.
- FIELD_W, 4, width of each decoded field.
- RESET_VALUE, 16'h0000, register contents after reset.

Ports:
- CLK  input  1  system clock; rising edge active.
- RST_N  input  1  asynchronous, active-low reset.
- IRWrite  input  1  load enable.
- in_instruction  input  16  instruction word from memory.
- out_opcode  output  4  instruction bits [3:0].
- out_Reg1  output  4  first source register, bits [11:8].
- out_Reg2  output  4  second source register, bits [7:4].
- out_RegRd  output  4  destination register, bits [15:12].
- out_instruction  output  16  full held instruction word.
- out_valid  output  1  high once at least one load has occurred since reset.

Behaviour:
- Storage: a single 16-bit register, ir, plus a 1-bit valid flag.
- Reset: RST_N low clears ir to RESET_VALUE and clears valid immediately, independent of CLK.
  - All outputs read 0 while RST_N is low.
  - Reset dominates IRWrite.
- Reset release: loading resumes on the first rising CLK edge with RST_N high.
- Load: on a rising CLK edge with RST_N=1 and IRWrite=1, ir <= in_instruction and valid <= 1.
- Hold: with IRWrite=0, ir and valid hold indefinitely, regardless of in_instruction activity.
- Latency: outputs reflect the new word immediately after the loading edge (one-edge latency).
  - in_instruction has no combinational path to any output.
- Decode: combinational slices of ir only, with no sign extension and no opcode-dependent interpretation:
  - out_RegRd = ir[15:12]
  - out_Reg1 = ir[11:8]
  - out_Reg2 = ir[7:4]
  - out_opcode = ir[3:0]
  - out_instruction = ir
- Fields are reported identically for all formats; downstream logic ignores irrelevant fields.
- IRWrite is sampled only at rising edges; glitches between edges have no effect.
- X or Z on in_instruction while IRWrite=0 must not propagate to any output.

Optional Feature:
- Macro: IR_PREV_EN.
- Defined:
  - Adds output out_prev_instruction (16 bits).
  - On every load, out_prev_instruction receives the old ir value, in the same edge that ir receives in_instruction.
  - Cleared to 0 by reset.
  - Holds when IRWrite=0.
- Undefined: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset: drive RST_N=0 mid-cycle with ir=16'hB0C0 -> all outputs 0 and out_valid=0 immediately, before any clock edge.
- Load: IRWrite=1, in_instruction=16'b1011_0000_1100_0000, one rising edge -> out_RegRd=11, out_Reg1=0, out_Reg2=12, out_opcode=0, out_valid=1.
- Hold: after the load above, IRWrite=0, in_instruction=16'h2251, several edges -> outputs still 11/0/12/0 and out_instruction=16'hB0C0.
- Back-to-back loads: IRWrite=1, in_instruction=16'h1234 then 16'hFEDC on consecutive edges -> after the second edge RegRd=15, Reg1=14, Reg2=13, opcode=12.
- Async reset priority: RST_N=0 held across an edge with IRWrite=1 -> register stays 0.
  - Release RST_N, then one edge with IRWrite=1 and 16'h5A3C -> RegRd=5, Reg1=10, Reg2=3, opcode=12.
- IR_PREV_EN: load 16'hB0C0 then 16'h2251 -> out_prev_instruction=16'hB0C0; reset -> 0.

Source files
------------

// File: rtl/instruction_register.sv
// Instruction register for the multicycle datapath: holds the fetched word and slices it into decode fields.
// Optional IR_PREV_EN macro adds out_prev_instruction, the word displaced by the most recent load.
module instruction_register #(
    parameter int              INSTR_W     = 16,
    parameter int              FIELD_W     = 4,
    parameter logic [INSTR_W-1:0] RESET_VALUE = 16'h0000
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               IRWrite,
    input  logic [INSTR_W-1:0] in_instruction,
    output logic [FIELD_W-1:0] out_opcode,
    output logic [FIELD_W-1:0] out_Reg1,
    output logic [FIELD_W-1:0] out_Reg2,
    output logic [FIELD_W-1:0] out_RegRd,
    output logic [INSTR_W-1:0] out_instruction,
`ifdef IR_PREV_EN
    output logic [INSTR_W-1:0] out_prev_instruction,
`endif
    output logic               out_valid
);

    // Field order matches the word layout, MSB first: rd | rs1 | rs2 | opcode.
    typedef struct packed {
        logic [FIELD_W-1:0] rd;
        logic [FIELD_W-1:0] r1;
        logic [FIELD_W-1:0] r2;
        logic [FIELD_W-1:0] op;
    } ir_fields_t;

    ir_fields_t ir;
    logic       valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ir    <= ir_fields_t'(RESET_VALUE);
            valid <= 1'b0;
        end else if (IRWrite) begin
            ir    <= ir_fields_t'(in_instruction);
            valid <= 1'b1;
        end
    end

`ifdef IR_PREV_EN
    logic [INSTR_W-1:0] prev;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            prev <= '0;
        else if (IRWrite)
            prev <= ir;
    end

    assign out_prev_instruction = prev;
`endif

    // Decode is pure slicing of the held word; in_instruction never reaches an output directly.
    assign out_RegRd       = ir.rd;
    assign out_Reg1        = ir.r1;
    assign out_Reg2        = ir.r2;
    assign out_opcode      = ir.op;
    assign out_instruction = ir;
    assign out_valid       = valid;

endmodule

// File: tb/tb_instruction_register.sv
// Directed + random bench for instruction_register; expected outputs queued at drive time, popped after the edge.
module tb_instruction_register;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IRWrite;
    logic [15:0] in_instruction;
    logic [3:0]  out_opcode, out_Reg1, out_Reg2, out_RegRd;
    logic [15:0] out_instruction;
    logic        out_valid;
`ifdef IR_PREV_EN
    logic [15:0] out_prev_instruction;
`endif

    instruction_register dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .IRWrite        (IRWrite),
        .in_instruction (in_instruction),
        .out_opcode     (out_opcode),
        .out_Reg1       (out_Reg1),
        .out_Reg2       (out_Reg2),
        .out_RegRd      (out_RegRd),
        .out_instruction(out_instruction),
`ifdef IR_PREV_EN
        .out_prev_instruction(out_prev_instruction),
`endif
        .out_valid      (out_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  rd, r1, r2, op;
        logic [15:0] instr;
        logic        valid;
        logic [15:0] prev;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference state
    logic [15:0] m_ir = 16'h0;
    logic        m_valid = 1'b0;
    logic [15:0] m_prev = 16'h0;

    task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] rd, r1, r2, op, input logic [15:0] instr,
                        input logic valid, input logic [15:0] prev);
        exp_t e;
        e.rd = rd; e.r1 = r1; e.r2 = r2; e.op = op;
        e.instr = instr; e.valid = valid; e.prev = prev;
        sb.push_back(e);
    endtask

    task automatic push_model();
        push(m_ir[15:12], m_ir[11:8], m_ir[7:4], m_ir[3:0], m_ir, m_valid, m_prev);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty, got %h expected an entry", tag, out_instruction);
            return;
        end
        e = sb.pop_front();
        cmp({tag, ".rd"},    {12'h0, out_RegRd},  {12'h0, e.rd});
        cmp({tag, ".r1"},    {12'h0, out_Reg1},   {12'h0, e.r1});
        cmp({tag, ".r2"},    {12'h0, out_Reg2},   {12'h0, e.r2});
        cmp({tag, ".op"},    {12'h0, out_opcode}, {12'h0, e.op});
        cmp({tag, ".instr"}, out_instruction,     e.instr);
        cmp({tag, ".valid"}, {15'h0, out_valid},  {15'h0, e.valid});
`ifdef IR_PREV_EN
        cmp({tag, ".prev"},  out_prev_instruction, e.prev);
`endif
    endtask

    // One clock: drive at negedge, advance the model, sample 1 time unit after the rising edge.
    task automatic cycle(input string tag, input logic wr, input logic [15:0] d);
        @(negedge CLK);
        IRWrite = wr;
        in_instruction = d;
        if (RST_N && wr) begin
            m_prev  = m_ir;
            m_ir    = d;
            m_valid = 1'b1;
        end
        push_model();
        @(posedge CLK);
        #1;
        check(tag);
    endtask

    task automatic model_reset();
        m_ir = 16'h0; m_valid = 1'b0; m_prev = 16'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0;
        IRWrite = 1'b0;
        in_instruction = 16'h0;
        #3;
        model_reset();
        push(4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 16'h0);
        check("reset");

        @(negedge CLK);
        RST_N = 1'b1;

        // Load 0xB0C0 and check against the literal field values
        @(negedge CLK);
        IRWrite = 1'b1;
        in_instruction = 16'b1011_0000_1100_0000;
        m_prev = m_ir; m_ir = 16'hB0C0; m_valid = 1'b1;
        push(4'd11, 4'd0, 4'd12, 4'd0, 16'hB0C0, 1'b1, 16'h0000);
        @(posedge CLK);
        #1;
        check("load_b0c0");

        // Hold under input activity
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            IRWrite = 1'b0;
            in_instruction = 16'h2251;
            push(4'd11, 4'd0, 4'd12, 4'd0, 16'hB0C0, 1'b1, 16'h0000);
            @(posedge CLK);
            #1;
            check("hold");
        end

        // X on the input while not loading must not leak
        @(negedge CLK);
        in_instruction = 16'hxxxx;
        #1;
        push(4'd11, 4'd0, 4'd12, 4'd0, 16'hB0C0, 1'b1, 16'h0000);
        check("x_comb");
        cycle("x_hold", 1'b0, 16'hxxxx);

`ifdef IR_PREV_EN
        cycle("prev_load", 1'b1, 16'h2251);
        cmp("prev_b0c0", out_prev_instruction, 16'hB0C0);
`endif

        // Mid-cycle async reset: outputs clear before any edge
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        push(4'd0, 4'd0, 4'd0, 4'd0, 16'h0, 1'b0, 16'h0);
        check("async_reset");

        // Reset dominates IRWrite across an edge
        cycle("reset_priority", 1'b1, 16'hFFFF);

        @(negedge CLK);
        RST_N = 1'b1;
        IRWrite = 1'b0;
        @(negedge CLK);
        IRWrite = 1'b1;
        in_instruction = 16'h5A3C;
        m_prev = m_ir; m_ir = 16'h5A3C; m_valid = 1'b1;
        push(4'd5, 4'd10, 4'd3, 4'd12, 16'h5A3C, 1'b1, 16'h0000);
        @(posedge CLK);
        #1;
        check("post_reset_load");

        // Back-to-back loads
        cycle("b2b_1", 1'b1, 16'h1234);
        @(negedge CLK);
        in_instruction = 16'hFEDC;
        m_prev = m_ir; m_ir = 16'hFEDC;
        push(4'd15, 4'd14, 4'd13, 4'd12, 16'hFEDC, 1'b1, 16'h1234);
        @(posedge CLK);
        #1;
        check("b2b_2");

        // Random load/hold mix
        for (int i = 0; i < 40; i++)
            cycle("random", 1'($urandom_range(0, 1)), 16'($urandom));

        @(negedge CLK);
        IRWrite = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
